ysyx_22041071_mul_ctrl: RTL and testbench
=========================================

Name: ysyx_22041071_mul_ctrl

Overview:
Sequencer for the iterative radix-4 Booth multiplier in the EXU.
- Accepts one multiply request at a time and extends the operands.
- Each busy cycle it decodes one Booth triplet and drives the partial-product selects (neg, pos, dou_neg, dou_pos) for a 132-bit partial-product generator. It then accumulates the result and shifts.
- Returns a 128-bit product, or the sign-extended low word for the W forms, through a valid/ready handshake. Flush squashes the in-flight operation.

Parameters:
XLEN, 64, operand width; accumulator width is 2*XLEN+4.
ITER_FULL, 33, Booth iterations for a full-width op ((XLEN+2)/2).
ITER_W, 17, Booth iterations for a W op ((32+2)/2).

Ports:
clk  in  1  clock.
rst_n  in  1  synchronous active-low reset.
mul_valid  in  1  request valid.
mul_ready  out  1  block can accept a request.
mul_signed  in  2  {rs1_signed, rs2_signed}: 11 = MUL/MULH, 10 = MULHSU, 00 = MULHU; 01 is illegal and treated as 00.
mulw  in  1  32-bit W operation.
multiplicand  in  XLEN  rs1.
multiplier  in  XLEN  rs2.
flush  in  1  kill the current operation.
out_valid  out  1  result valid.
out_ready  in  1  consumer accepts the result.
result_hi  out  XLEN  product[127:64]; 0 when mulw.
result_lo  out  XLEN  product[63:0]; sext(product[31:0]) when mulw.

Behaviour:
- Clock and reset:
  - One clock.
  - Reset is synchronous and active-low on rst_n.
  - On reset: state = IDLE, mul_ready = 1, out_valid = 0, result_hi = result_lo = 0, accumulator = 0, counter = 0.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - mul_ready = 1.
  - On mul_valid && mul_ready, latch the request and go to BUSY.
  - Multiplicand is extended to 132 bits: sign-extended if rs1_signed, zero-extended otherwise.
  - Multiplier is extended to 66 bits the same way using rs2_signed, with an implicit bit[-1] = 0.
  - When mulw, both operands are first taken from bits [31:0] and extended per the same rules.
  - Counter is loaded with ITER_W if mulw, else ITER_FULL.
  - Accumulator is cleared.
- BUSY:
  - mul_ready = 0.
  - Each cycle, Booth-decode triplet {mr[1], mr[0], mr_prev}:
    - 000 / 111: all selects 0.
    - 001 / 010: pos.
    - 011: dou_pos.
    - 100: dou_neg.
    - 101 / 110: neg.
  - Selects are one-hot or all-zero, never more than one high.
  - acc <= acc + pp, mod 2^132.
  - mcand <= mcand << 2.
  - mr_prev <= mr[1].
  - mr <= mr >> 2, arithmetic shift.
  - Counter decrements by 1. When the counter reaches 1 during the update, go to DONE.
- Latency: 33 cycles BUSY for full-width ops and 17 for W ops, from acceptance to out_valid. out_valid rises the cycle after the last accumulate.
- DONE:
  - out_valid = 1, and results are registered from the accumulator.
  - Results are held stable until out_valid && out_ready, then go to IDLE.
  - mul_ready stays 0 in DONE, so there is no back-to-back accept in the handoff cycle.
- flush:
  - In any state, state <= IDLE next cycle and out_valid <= 0.
  - Any in-flight or held result is discarded.
  - mul_valid in the same cycle as flush is ignored.
  - flush has priority over every other event.
- out_ready while not out_valid: no effect.
- mul_valid while BUSY or DONE: ignored, no latching.
- Overflow: the product wraps mod 2^128. 0x8000...0 × 0x8000...0 signed gives hi = 0x4000_0000_0000_0000, lo = 0.

Optional Feature:
Macro: YSYX_22041071_MUL_EARLY_EXIT_EN.
- Defined: in BUSY, if the remaining multiplier bits {mr, mr_prev} are all 0 or all 1, every later select is zero. The FSM goes to DONE at the end of the current cycle regardless of the counter. The product is bit-identical to the non-early-exit result.
- Undefined: the fixed 33/17-cycle latency is always used.

Test Plan:
1. Reset: hold rst_n = 0 for 2 cycles → mul_ready = 1, out_valid = 0, results 0. Then MUL 7 × 6 signed → out_valid after 33 cycles (macro off), hi = 0, lo = 42.
2. Signed: 0xFFFF_FFFF_FFFF_FFFF (−1) × 3, mul_signed = 11 → hi = 0xFFFF_FFFF_FFFF_FFFF, lo = 0xFFFF_FFFF_FFFF_FFFD. Same operands with mul_signed = 00 → hi = 2, lo = 0xFFFF_FFFF_FFFF_FFFD.
3. MULHSU: rs1 = −2, rs2 = 0xFFFF_FFFF_FFFF_FFFF, mul_signed = 10 → hi = 0xFFFF_FFFF_FFFF_FFFE, lo = 2.
4. MULW: 0x0000_0000_7FFF_FFFF × 2, mulw = 1 → lo = 0xFFFF_FFFF_FFFF_FFFE, hi = 0, latency 17 cycles.
5. Backpressure and flush:
   - Hold out_ready = 0 for 5 cycles after out_valid → result stable and mul_ready = 0.
   - Assert flush at BUSY cycle 10 → IDLE next cycle, no out_valid.
   - Next request 5 × 5 → lo = 25.
6. Early exit (macro on): multiplier = 1 → out_valid within 2 BUSY cycles, lo = multiplicand. Multiplier = 0x8000_0000_0000_0000 → full latency, correct product.

Source files
------------

// File: rtl/ysyx_22041071_mul_ctrl.sv
// ysyx_22041071_mul_ctrl: sequencer for the iterative radix-4 Booth multiplier.
// Each busy cycle retires one Booth digit into a (2*XLEN+4)-bit accumulator.
// The product is returned through a valid/ready handshake, and flush kills
// the operation that is in flight.
// Optional: define YSYX_22041071_MUL_EARLY_EXIT_EN to finish as soon as the
// remaining multiplier bits can only produce zero partial products.
module ysyx_22041071_mul_ctrl #(
    parameter int XLEN      = 64,
    parameter int ITER_FULL = 33,
    parameter int ITER_W    = 17
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mul_valid,
    output logic            mul_ready,
    input  logic [1:0]      mul_signed,
    input  logic            mulw,
    input  logic [XLEN-1:0] multiplicand,
    input  logic [XLEN-1:0] multiplier,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result_hi,
    output logic [XLEN-1:0] result_lo
);

    localparam int ACC_W = 2 * XLEN + 4;
    localparam int MR_W  = XLEN + 2;
    localparam int CNT_W = 6;

    localparam logic [ACC_W-1:0] ACC_ONE  = {{(ACC_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ITER_FULL);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(ITER_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Booth radix-4 digit decode, returned as {neg, pos, dou_neg, dou_pos}.
    function automatic logic [3:0] booth_sel(input logic [2:0] trip);
        logic [3:0] sel;
        case (trip)
            3'b001, 3'b010: sel = 4'b0100;
            3'b011:         sel = 4'b0001;
            3'b100:         sel = 4'b0010;
            3'b101, 3'b110: sel = 4'b1000;
            default:        sel = 4'b0000;
        endcase
        return sel;
    endfunction

    state_t            state_r, state_nxt_s;
    logic [ACC_W-1:0]  mcand_r, mcand_nxt_s;
    logic [MR_W-1:0]   mr_r, mr_nxt_s;
    logic              mr_prev_r, mr_prev_nxt_s;
    logic [ACC_W-1:0]  acc_r, acc_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic              w_r, w_nxt_s;
    logic              ready_r, ready_nxt_s;
    logic              valid_r, valid_nxt_s;
    logic [XLEN-1:0]   hi_r, hi_nxt_s;
    logic [XLEN-1:0]   lo_r, lo_nxt_s;

    logic              rs1_signed_s, rs2_signed_s;
    logic [XLEN-1:0]   op1_s, op2_s;
    logic [ACC_W-1:0]  mcand_ext_s;
    logic [MR_W-1:0]   mr_ext_s;
    logic [3:0]        sel_s;
    logic              neg_s, pos_s, dou_neg_s, dou_pos_s;
    logic [ACC_W-1:0]  pp_s, acc_sum_s;
    logic              early_s, finish_s;

    assign mul_ready = ready_r;
    assign out_valid = valid_r;
    assign result_hi = hi_r;
    assign result_lo = lo_r;

    // Operand extension; mul_signed = 01 collapses to unsigned x unsigned.
    always_comb begin
        rs1_signed_s = mul_signed[1];
        rs2_signed_s = mul_signed[1] & mul_signed[0];
        if (mulw) begin
            op1_s = {{(XLEN-32){rs1_signed_s & multiplicand[31]}}, multiplicand[31:0]};
            op2_s = {{(XLEN-32){rs2_signed_s & multiplier[31]}}, multiplier[31:0]};
        end else begin
            op1_s = multiplicand;
            op2_s = multiplier;
        end
        mcand_ext_s = {{(ACC_W-XLEN){rs1_signed_s & op1_s[XLEN-1]}}, op1_s};
        mr_ext_s    = {{(MR_W-XLEN){rs2_signed_s & op2_s[XLEN-1]}}, op2_s};
    end

    assign sel_s     = booth_sel({mr_r[1:0], mr_prev_r});
    assign neg_s     = sel_s[3];
    assign pos_s     = sel_s[2];
    assign dou_neg_s = sel_s[1];
    assign dou_pos_s = sel_s[0];

    // Partial-product generator driven by the one-hot selects.
    always_comb begin
        pp_s = {ACC_W{1'b0}};
        if (pos_s) begin
            pp_s = mcand_r;
        end else if (dou_pos_s) begin
            pp_s = mcand_r << 1;
        end else if (neg_s) begin
            pp_s = ~mcand_r + ACC_ONE;
        end else if (dou_neg_s) begin
            pp_s = ~(mcand_r << 1) + ACC_ONE;
        end else begin
            pp_s = {ACC_W{1'b0}};
        end
    end

    assign acc_sum_s = acc_r + pp_s;

`ifdef YSYX_22041071_MUL_EARLY_EXIT_EN
    // Remaining bits all equal means every later digit decodes to zero.
    assign early_s = (~|{mr_r, mr_prev_r}) | (&{mr_r, mr_prev_r});
`else
    assign early_s = 1'b0;
`endif

    assign finish_s = (cnt_r == CNT_ONE) | early_s;

    // Next-state and datapath update; flush overrides every other event.
    always_comb begin
        state_nxt_s   = state_r;
        mcand_nxt_s   = mcand_r;
        mr_nxt_s      = mr_r;
        mr_prev_nxt_s = mr_prev_r;
        acc_nxt_s     = acc_r;
        cnt_nxt_s     = cnt_r;
        w_nxt_s       = w_r;
        ready_nxt_s   = ready_r;
        valid_nxt_s   = valid_r;
        hi_nxt_s      = hi_r;
        lo_nxt_s      = lo_r;
        if (flush) begin
            state_nxt_s = IDLE;
            valid_nxt_s = 1'b0;
            ready_nxt_s = 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    if (mul_valid) begin
                        state_nxt_s   = BUSY;
                        ready_nxt_s   = 1'b0;
                        mcand_nxt_s   = mcand_ext_s;
                        mr_nxt_s      = mr_ext_s;
                        mr_prev_nxt_s = 1'b0;
                        acc_nxt_s     = {ACC_W{1'b0}};
                        cnt_nxt_s     = mulw ? CNT_HALF : CNT_FULL;
                        w_nxt_s       = mulw;
                    end else begin
                        ready_nxt_s = 1'b1;
                    end
                end
                BUSY: begin
                    acc_nxt_s     = acc_sum_s;
                    mcand_nxt_s   = mcand_r << 2;
                    mr_prev_nxt_s = mr_r[1];
                    mr_nxt_s      = {{2{mr_r[MR_W-1]}}, mr_r[MR_W-1:2]};
                    cnt_nxt_s     = cnt_r - CNT_ONE;
                    if (finish_s) begin
                        state_nxt_s = DONE;
                        valid_nxt_s = 1'b1;
                        if (w_r) begin
                            hi_nxt_s = {XLEN{1'b0}};
                            lo_nxt_s = {{(XLEN-32){acc_sum_s[31]}}, acc_sum_s[31:0]};
                        end else begin
                            hi_nxt_s = acc_sum_s[2*XLEN-1:XLEN];
                            lo_nxt_s = acc_sum_s[XLEN-1:0];
                        end
                    end else begin
                        state_nxt_s = BUSY;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_nxt_s = IDLE;
                        valid_nxt_s = 1'b0;
                        ready_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = DONE;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                    valid_nxt_s = 1'b0;
                    ready_nxt_s = 1'b1;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            mcand_r   <= {ACC_W{1'b0}};
            mr_r      <= {MR_W{1'b0}};
            mr_prev_r <= 1'b0;
            acc_r     <= {ACC_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            w_r       <= 1'b0;
            ready_r   <= 1'b1;
            valid_r   <= 1'b0;
            hi_r      <= {XLEN{1'b0}};
            lo_r      <= {XLEN{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            mcand_r   <= mcand_nxt_s;
            mr_r      <= mr_nxt_s;
            mr_prev_r <= mr_prev_nxt_s;
            acc_r     <= acc_nxt_s;
            cnt_r     <= cnt_nxt_s;
            w_r       <= w_nxt_s;
            ready_r   <= ready_nxt_s;
            valid_r   <= valid_nxt_s;
            hi_r      <= hi_nxt_s;
            lo_r      <= lo_nxt_s;
        end
    end

endmodule

// File: tb/tb_ysyx_22041071_mul_ctrl.sv
// Testbench for ysyx_22041071_mul_ctrl: directed steps with a result scoreboard.
// Honours YSYX_22041071_MUL_EARLY_EXIT_EN for the latency expectations.
module tb_ysyx_22041071_mul_ctrl;

    logic        clk;
    logic        rst_n;
    logic        mul_valid;
    logic        mul_ready;
    logic [1:0]  mul_signed;
    logic        mulw;
    logic [63:0] multiplicand;
    logic [63:0] multiplier;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result_hi;
    logic [63:0] result_lo;

    typedef struct {
        logic [63:0] hi;
        logic [63:0] lo;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   total;
    int   bad;

    ysyx_22041071_mul_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mul_valid    (mul_valid),
        .mul_ready    (mul_ready),
        .mul_signed   (mul_signed),
        .mulw         (mulw),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result_hi    (result_hi),
        .result_lo    (result_lo)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Reference product: extend both operands to 130 bits and multiply.
    function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                             input logic [1:0] sg, input logic w);
        logic         s1;
        logic         s2;
        logic [129:0] ea;
        logic [129:0] eb;
        logic [129:0] p;
        s1 = sg[1];
        s2 = sg[1] & sg[0];
        if (w) begin
            ea = {{98{s1 & a[31]}}, a[31:0]};
            eb = {{98{s2 & b[31]}}, b[31:0]};
        end else begin
            ea = {{66{s1 & a[63]}}, a};
            eb = {{66{s2 & b[63]}}, b};
        end
        p = ea * eb;
        if (w) return {64'd0, {32{p[31]}}, p[31:0]};
        return p[127:0];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [1:0] sg,
                         input logic w, input logic [63:0] eh, input logic [63:0] el,
                         input int elat);
        exp_t e;
        chk("ready_at_issue", {63'd0, mul_ready}, 64'd1);
        multiplicand = a;
        multiplier   = b;
        mul_signed   = sg;
        mulw         = w;
        mul_valid    = 1'b1;
        @(posedge clk); #1;
        mul_valid = 1'b0;
        e.hi  = eh;
        e.lo  = el;
        e.lat = elat;
        sb.push_back(e);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_out(input string tag, input int lat);
        exp_t e;
        e = sb.pop_front();
        chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        chk({tag, "_hi"}, result_hi, e.hi);
        chk({tag, "_lo"}, result_lo, e.lo);
`ifdef YSYX_22041071_MUL_EARLY_EXIT_EN
        chk({tag, "_lat_le"}, {63'd0, (lat <= e.lat)}, 64'd1);
`else
        chk({tag, "_lat"}, 64'(lat), 64'(e.lat));
`endif
    endtask

    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [1:0] sg, input logic w, input logic [63:0] eh,
                          input logic [63:0] el, input int elat);
        int lat;
        issue(a, b, sg, w, eh, el, elat);
        wait_out(lat);
        check_out(tag, lat);
        @(posedge clk); #1;
        chk({tag, "_drop"}, {63'd0, out_valid}, 64'd0);
    endtask

    task automatic run_model(input string tag, input logic [63:0] a, input logic [63:0] b,
                             input logic [1:0] sg, input logic w);
        logic [127:0] p;
        p = ref_mul(a, b, sg, w);
        run_op(tag, a, b, sg, w, p[127:64], p[63:0], w ? 17 : 33);
    endtask

    initial begin
        int          lat;
        int          rises;
        logic [63:0] hold_hi;
        logic [63:0] hold_lo;
        logic [63:0] ra;
        logic [63:0] rb;
        logic [1:0]  rs;
        exp_t        dropped;
        total        = 0;
        bad          = 0;
        rst_n        = 1'b0;
        mul_valid    = 1'b0;
        mul_signed   = 2'b00;
        mulw         = 1'b0;
        multiplicand = 64'd0;
        multiplier   = 64'd0;
        flush        = 1'b0;
        out_ready    = 1'b1;

        // Step 1: reset values.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {63'd0, mul_ready}, 64'd1);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_hi", result_hi, 64'd0);
        chk("rst_lo", result_lo, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("mul_7x6", 64'd7, 64'd6, 2'b11, 1'b0, 64'd0, 64'd42, 33);

        // Step 2: signed versus unsigned interpretation.
        run_op("mulh_m1x3", 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 2'b11, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFD, 33);
        run_op("mulhu_m1x3", 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 2'b00, 1'b0,
               64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);
        run_op("illegal01_m1x3", 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 2'b01, 1'b0,
               64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 33);

        // Step 3: MULHSU.
        run_op("mulhsu", 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 2'b10, 1'b0,
               64'hFFFF_FFFF_FFFF_FFFE, 64'd2, 33);

        // Step 4: W forms.
        run_op("mulw_7fff", 64'h0000_0000_7FFF_FFFF, 64'd2, 2'b11, 1'b1,
               64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 17);
        run_op("mulw_upper_ignored", 64'hDEAD_BEEF_0000_0003, 64'h1234_5678_FFFF_FFFF, 2'b11, 1'b1,
               64'd0, 64'hFFFF_FFFF_FFFF_FFFD, 17);

        // Overflow corner: most negative squared.
        run_op("min_sq", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b11, 1'b0,
               64'h4000_0000_0000_0000, 64'd0, 33);

        // Random operands against the reference product.
        for (int i = 0; i < 6; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 2))
                0:       rs = 2'b11;
                1:       rs = 2'b10;
                default: rs = 2'b00;
            endcase
            run_model("rand", ra, rb, rs, 1'(i % 2));
        end

        // Step 5a: backpressure; requests while busy/done are ignored.
        out_ready = 1'b0;
        issue(64'd11, 64'd13, 2'b11, 1'b0, 64'd0, 64'd143, 33);
        multiplicand = 64'd99;
        multiplier   = 64'd99;
        mul_valid    = 1'b1;
        wait_out(lat);
        check_out("bp", lat);
        hold_hi = 64'd0;
        hold_lo = 64'd143;
        repeat (5) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_hold_ready", {63'd0, mul_ready}, 64'd0);
            chk("bp_hold_hi", result_hi, hold_hi);
            chk("bp_hold_lo", result_lo, hold_lo);
        end
        mul_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", {63'd0, out_valid}, 64'd0);
        chk("bp_release_ready", {63'd0, mul_ready}, 64'd1);

        // Step 5b: flush at busy cycle 10, with a same-cycle request that must be ignored.
        issue(64'd9, 64'd9, 2'b11, 1'b0, 64'd0, 64'd81, 33);
        repeat (9) @(posedge clk);
        #1;
        flush        = 1'b1;
        mul_valid    = 1'b1;
        multiplicand = 64'd3;
        multiplier   = 64'd3;
        @(posedge clk); #1;
        flush     = 1'b0;
        mul_valid = 1'b0;
        dropped   = sb.pop_front();
        chk("flush_busy_ready", {63'd0, mul_ready}, 64'd1);
        chk("flush_busy_valid", {63'd0, out_valid}, 64'd0);
        rises = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) rises++;
        end
        chk("flush_busy_no_out", 64'(rises), 64'd0);
        run_op("after_flush_5x5", 64'd5, 64'd5, 2'b11, 1'b0, 64'd0, 64'd25, 33);

        // Step 5c: flush while a result is held.
        out_ready = 1'b0;
        issue(64'd4, 64'd8, 2'b00, 1'b0, 64'd0, 64'd32, 33);
        wait_out(lat);
        check_out("flush_done_pre", lat);
        flush = 1'b1;
        @(posedge clk); #1;
        flush     = 1'b0;
        out_ready = 1'b1;
        chk("flush_done_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_done_ready", {63'd0, mul_ready}, 64'd1);
        @(posedge clk); #1;

        // Step 6: early-exit candidates; exact latency depends on the build.
`ifdef YSYX_22041071_MUL_EARLY_EXIT_EN
        run_op("ee_mr1", 64'h1234_5678_9ABC_DEF0, 64'd1, 2'b11, 1'b0,
               64'd0, 64'h1234_5678_9ABC_DEF0, 2);
`else
        run_op("ee_mr1", 64'h1234_5678_9ABC_DEF0, 64'd1, 2'b11, 1'b0,
               64'd0, 64'h1234_5678_9ABC_DEF0, 33);
`endif
        issue(64'd3, 64'h8000_0000_0000_0000, 2'b11, 1'b0,
              64'hFFFF_FFFF_FFFF_FFFE, 64'h8000_0000_0000_0000, 33);
        wait_out(lat);
        check_out("ee_mr_min", lat);
        chk("ee_mr_min_full_lat", 64'(lat), 64'd33);
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
